// File: rtl/unsigned_mul_add_seq.sv
// unsigned_mul_add_seq: sequential shift-and-add recombiner.
// Rebuilds dividend = quot * divisor + rem over W RUN cycles so the divider
// can be checked on chip by round trip.
//
// Optional feature macro: DIVCHK_EN (adds rem_ok / range_err checking;
// without it both ports are tied to 0).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request, sampled only in IDLE
//   quot       W-bit quotient operand, captured with start
//   divisor    W-bit divisor operand, captured with start
//   rem        W-bit remainder operand, captured with start
//   busy       high while the multiply is running
//   done       one-cycle pulse when dividend is updated
//   dividend   2W-bit result, held until the next done or reset
//   rem_ok     rem < divisor and divisor != 0 (DIVCHK_EN only)
//   range_err  result does not fit W bits (DIVCHK_EN only)
module unsigned_mul_add_seq #(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     quot,
  input  logic [W-1:0]     divisor,
  input  logic [W-1:0]     rem,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   dividend,
  output logic             rem_ok,
  output logic             range_err
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned CW = ($clog2(W) > 0) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   acc_q, acc_d;
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_d, done_d;
  logic [RW-1:0]   dividend_d;
`ifdef DIVCHK_EN
  logic            rem_ok_d, range_err_d;
`endif

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    dividend_d = dividend;
`ifdef DIVCHK_EN
    rem_ok_d    = rem_ok;
    range_err_d = range_err;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          // Seeding acc with rem folds the final addition into the start.
          acc_d    = RW'(rem);
          mcand_d  = RW'(divisor);
          mplier_d = quot;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
`ifdef DIVCHK_EN
          rem_ok_d = (divisor != '0) && (rem < divisor);
`endif
        end
      end
      RUN: begin
        busy_d = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          // Last partial product: publish the updated accumulator directly.
          busy_d     = 1'b0;
          done_d     = 1'b1;
          dividend_d = acc_d;
          state_d    = DONE;
`ifdef DIVCHK_EN
          range_err_d = |acc_d[RW-1:W];
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dividend <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy     <= busy_d;
      done     <= done_d;
      dividend <= dividend_d;
    end
  end

`ifdef DIVCHK_EN
  // Divider-legality flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_ok    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      rem_ok    <= rem_ok_d;
      range_err <= range_err_d;
    end
  end
`else
  assign rem_ok    = 1'b0;
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_unsigned_mul_add_seq.sv
// Scoreboard bench for unsigned_mul_add_seq: the driver pushes the expected
// result (plain arithmetic) when it issues a request; a monitor pops and
// compares on every done pulse, including the done timing.
module tb_unsigned_mul_add_seq;

  localparam int unsigned W  = 4;
  localparam int unsigned RW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  quot, divisor, rem;
  logic          busy, done, rem_ok, range_err;
  logic [RW-1:0] dividend;

  typedef struct {
    logic [RW-1:0] div;
    logic          rok;
    logic          rerr;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_done = 0;
  logic [RW-1:0] last_div;

  unsigned_mul_add_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .quot      (quot),
    .divisor   (divisor),
    .rem       (rem),
    .busy      (busy),
    .done      (done),
    .dividend  (dividend),
    .rem_ok    (rem_ok),
    .range_err (range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: the result straight from the arithmetic definition.
  function automatic exp_t model(input int q, input int d, input int r, input int due);
    exp_t e;
    int   v;
    v      = q * d + r;
    e.div  = RW'(v);
`ifdef DIVCHK_EN
    e.rok  = (d != 0) && (r < d);
    e.rerr = (v > (2 ** W) - 1);
`else
    e.rok  = 1'b0;
    e.rerr = 1'b0;
`endif
    e.due  = due;
    return e;
  endfunction

  // Monitor: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      n_done = n_done + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("dividend", longint'(dividend), longint'(e.div));
        chk("rem_ok", longint'(rem_ok), longint'(e.rok));
        chk("range_err", longint'(range_err), longint'(e.rerr));
        chk("done_cycle", longint'(cyc), longint'(e.due));
        chk("busy_at_done", longint'(busy), 0);
      end
    end
`ifndef DIVCHK_EN
    chk("rem_ok_tied", longint'(rem_ok), 0);
    chk("range_err_tied", longint'(range_err), 0);
`endif
  end

  // Issue one request; push its expectation when it is meant to complete.
  task automatic issue(input int q, input int d, input int r, input bit push);
    @(negedge clk);
    quot    = W'(q);
    divisor = W'(d);
    rem     = W'(r);
    start   = 1'b1;
    if (push) begin
      exp_q.push_back(model(q, d, r, cyc + 1 + W));
      last_div = RW'(q * d + r);
    end
    @(negedge clk);
    start   = 1'b0;
    chk("busy_after_start", longint'(busy), 1);
    // Captured copies must be used, so scramble the live operands.
    quot    = W'($urandom);
    divisor = W'($urandom);
    rem     = W'($urandom);
  endtask

  task automatic wait_done(input int target);
    int budget;
    budget = 0;
    while (n_done < target && budget < W + 8) begin
      @(negedge clk);
      budget = budget + 1;
    end
    if (n_done < target) chk("done_timeout", longint'(n_done), longint'(target));
  endtask

  task automatic run_one(input int q, input int d, input int r);
    int tgt;
    tgt = n_done + 1;
    issue(q, d, r, 1'b1);
    wait_done(tgt);
  endtask

  initial begin
    int tgt;
    rst = 1'b1; start = 1'b0; quot = '0; divisor = '0; rem = '0;
    last_div = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_dividend", longint'(dividend), 0);
    chk("rst_rem_ok", longint'(rem_ok), 0);
    chk("rst_range_err", longint'(range_err), 0);
    rst = 1'b0;

    run_one(3, 3, 1);
    @(negedge clk);
    chk("done_single_pulse", longint'(done), 0);
    chk("dividend_held", longint'(dividend), 10);
    run_one(15, 15, 15);
    run_one(5, 0, 9);

    // Start raised mid-run with other operands must be ignored.
    tgt = n_done + 1;
    issue(6, 7, 2, 1'b1);
    @(negedge clk);
    quot = 4'd1; divisor = 4'd1; rem = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tgt);
    repeat (4) @(negedge clk);
    chk("no_extra_done", longint'(n_done), longint'(tgt));

    // Reset during the second RUN cycle aborts with no done.
    tgt = n_done;
    issue(9, 10, 9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", longint'(busy), 0);
    chk("abort_done", longint'(done), 0);
    chk("abort_dividend", longint'(dividend), 0);
    chk("abort_rem_ok", longint'(rem_ok), 0);
    chk("abort_range_err", longint'(range_err), 0);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    chk("abort_no_done", longint'(n_done), longint'(tgt));
    run_one(2, 4, 0);

    // Randomized traffic with boundary operands mixed in.
    for (int i = 0; i < 40; i++) begin
      int q, d, r;
      q = (i % 7 == 0) ? 15 : int'($urandom_range(0, 15));
      d = (i % 5 == 0) ? 0  : int'($urandom_range(0, 15));
      r = (i % 6 == 0) ? 15 : int'($urandom_range(0, 15));
      run_one(q, d, r);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("dividend_stable", longint'(dividend), longint'(last_div));
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
